// File: rtl/datapath_exec_if.sv
// Sequencer <-> execute-datapath bundle: control/operand inputs and
// registered write-back results.
interface datapath_exec_if #(
  parameter int NREG = 16
);
  logic [15:0]     immediate;
  logic            buff_en;
  logic [NREG-1:0] enable;
  logic [4:0]      control1;
  logic [4:0]      control2;
  logic            imm_control;
  logic [7:0]      opcode;
  logic [15:0]     bus;
  logic [3:0]      flags;
  logic            wb_valid;
  logic            illegal_op;
  logic [15:0]     reg0_out;

  // Sequencer side: drives controls, observes results.
  modport master (
    output immediate, buff_en, enable, control1, control2, imm_control, opcode,
    input  bus, flags, wb_valid, illegal_op, reg0_out
  );

  // Datapath side.
  modport slave (
    input  immediate, buff_en, enable, control1, control2, imm_control, opcode,
    output bus, flags, wb_valid, illegal_op, reg0_out
  );
endinterface

// File: rtl/datapath_exec.sv
// Execute datapath: NREG x 16-bit register file, A/B operand latches,
// 10-op ALU with {C,V,N,Z} flags and single-cycle write-back.
module datapath_exec #(
  parameter int NREG = 16
) (
  input logic            clk,
  input logic            reset,
  datapath_exec_if.slave dp
);

  localparam int         IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [4:0] NREG_SEL = 5'(NREG);

  typedef enum logic [7:0] {
    OP_AND = 8'h01,
    OP_OR  = 8'h02,
    OP_XOR = 8'h03,
    OP_NOT = 8'h04,
    OP_ADD = 8'h05,
    OP_SUB = 8'h06,
    OP_CMP = 8'h07,
    OP_MOV = 8'h08,
    OP_SHL = 8'h09,
    OP_SHR = 8'h0A
  } op_e;

  logic [15:0] regs [NREG];
  logic [15:0] a_q, b_q, bus_q;
  logic [3:0]  flags_q;
  logic        wb_valid_q, illegal_q;

  // Register selects: code k selects register k-1; 0 or out-of-range means none.
  logic             a_sel_ok, b_sel_ok;
  logic [IDX_W-1:0] a_idx, b_idx;

  assign a_sel_ok = (dp.control1 != 5'd0) && (dp.control1 <= NREG_SEL);
  assign b_sel_ok = (dp.control2 != 5'd0) && (dp.control2 <= NREG_SEL);
  assign a_idx    = IDX_W'(dp.control1 - 5'd1);
  assign b_idx    = IDX_W'(dp.control2 - 5'd1);

  logic [15:0] op_b;
  logic [15:0] alu_res;
  logic        alu_c, alu_v, op_legal, op_is_cmp;
  logic [16:0] sum, diff;

  assign sum  = {1'b0, a_q} + {1'b0, op_b};
  assign diff = {1'b0, a_q} - {1'b0, op_b};

  // Operand B: latched immediate or a register read (pre-write value, no bypass).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    op_b = '0;
    if (dp.imm_control)
      op_b = b_q;
    else if (b_sel_ok)
      op_b = regs[b_idx];
  end

  // ALU: result, carry/overflow and legality decode of the opcode.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    op_legal  = 1'b1;
    op_is_cmp = 1'b0;
    case (dp.opcode)
      OP_AND: alu_res = a_q & op_b;
      OP_OR:  alu_res = a_q | op_b;
      OP_XOR: alu_res = a_q ^ op_b;
      OP_NOT: alu_res = ~a_q;
      OP_ADD: begin
        alu_res = sum[15:0];
        alu_c   = sum[16];
        alu_v   = (a_q[15] == op_b[15]) && (sum[15] != a_q[15]);
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff[15:0];
        alu_c     = ~diff[16];   // borrow-not
        alu_v     = (a_q[15] != op_b[15]) && (diff[15] != a_q[15]);
        op_is_cmp = (dp.opcode == OP_CMP);
      end
      OP_MOV: alu_res = op_b;
      OP_SHL: alu_res = a_q << op_b[3:0];
      OP_SHR: alu_res = a_q >> op_b[3:0];
      default: op_legal = 1'b0;
    endcase
  end

  // State update: operand latches, write-back, flags and status pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every read sees start-of-cycle values.
    if (reset) begin
      // NOTE: the register file is cleared on reset because its contents are architecturally visible.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      bus_q      <= '0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;

      if (a_sel_ok)
        a_q <= regs[a_idx];
      if (dp.imm_control && !dp.buff_en)
        b_q <= dp.immediate;

      if (dp.buff_en) begin
        if (!op_legal) begin
          illegal_q <= 1'b1;
        end else begin
          flags_q <= {alu_c, alu_v, alu_res[15], alu_res == 16'h0000};
          if (!op_is_cmp) begin
            bus_q      <= alu_res;
            wb_valid_q <= 1'b1;
            for (int i = 0; i < NREG; i++)
              if (dp.enable[i]) regs[i] <= alu_res;
          end
        end
      end
    end
  end

  assign dp.bus        = bus_q;
  assign dp.flags      = flags_q;
  assign dp.wb_valid   = wb_valid_q;
  assign dp.illegal_op = illegal_q;
  assign dp.reg0_out   = regs[0];

endmodule

// File: tb/tb_datapath_exec.sv
// Bench for datapath_exec: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_datapath_exec;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  datapath_exec_if #(.NREG(16)) dp ();
  datapath_exec #(.NREG(16)) dut (.clk(clk), .reset(reset), .dp(dp));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [16];
  logic [15:0] m_a, m_b, m_bus;
  logic [3:0]  m_flags;
  logic        m_wb, m_ill;
  bit          live = 0;

  task automatic model_step();
    int ua, ub, sa, sb, s, r, c1, c2;
    bit c, v, ok, cmp;
    logic [15:0] opb, a_next;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_a = 0; m_b = 0; m_bus = 0; m_flags = 0; m_wb = 0; m_ill = 0;
      live = 1;
      return;
    end
    c1     = int'(dp.control1);
    c2     = int'(dp.control2);
    opb    = dp.imm_control ? m_b : ((c2 >= 1 && c2 <= 16) ? m_regs[c2-1] : 16'h0);
    a_next = (c1 >= 1 && c1 <= 16) ? m_regs[c1-1] : m_a;
    m_wb   = 0;
    m_ill  = 0;
    if (dp.buff_en) begin
      ua = int'(m_a); ub = int'(opb);
      sa = $signed(m_a); sb = $signed(opb);
      c = 0; v = 0; ok = 1; cmp = 0; r = 0;
      case (int'(dp.opcode))
        1: r = ua & ub;
        2: r = ua | ub;
        3: r = ua ^ ub;
        4: r = 65535 - ua;
        5: begin
          s = ua + ub; r = s % 65536; c = (s > 65535);
          v = (sa + sb > 32767) || (sa + sb < -32768);
        end
        6, 7: begin
          r = (ua - ub + 65536) % 65536; c = (ua >= ub);
          v = (sa - sb > 32767) || (sa - sb < -32768);
          cmp = (dp.opcode == 8'h07);
        end
        8:  r = ub;
        9:  r = (ua << (ub % 16)) % 65536;
        10: r = ua >> (ub % 16);
        default: ok = 0;
      endcase
      if (!ok) m_ill = 1;
      else begin
        m_flags = {c, v, r >= 32768, r == 0};
        if (!cmp) begin
          m_bus = r[15:0];
          m_wb  = 1;
          for (int i = 0; i < 16; i++) if (dp.enable[i]) m_regs[i] = r[15:0];
        end
      end
    end
    if (dp.imm_control && !dp.buff_en) m_b = dp.immediate;
    m_a = a_next;
  endtask

  always @(posedge clk) model_step();

  // Compare DUT against model every cycle once reset has been applied.
  always @(negedge clk) begin
    if (live) begin
      check("reg0_out",   dp.reg0_out,           m_regs[0]);
      check("bus",        dp.bus,                m_bus);
      check("flags",      {12'h0, dp.flags},     {12'h0, m_flags});
      check("wb_valid",   {15'h0, dp.wb_valid},  {15'h0, m_wb});
      check("illegal_op", {15'h0, dp.illegal_op}, {15'h0, m_ill});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic be, input logic [7:0] op,
                       input logic [15:0] en, input logic [4:0] c1, input logic [4:0] c2,
                       input logic ic, input logic [15:0] imm);
    @(negedge clk);
    reset          = rst;
    dp.buff_en     = be;
    dp.opcode      = op;
    dp.enable      = en;
    dp.control1    = c1;
    dp.control2    = c2;
    dp.imm_control = ic;
    dp.immediate   = imm;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] corner [5];
  logic [15:0] rnd;

  initial begin
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'h0001;

    // Reset state.
    drive(1, 0, 8'h00, 16'h0, 0, 0, 0, 16'h0);
    check("rst_reg0",  dp.reg0_out, 16'h0000);
    check("rst_bus",   dp.bus, 16'h0000);
    check("rst_flags", {12'h0, dp.flags}, 16'h0000);
    check("rst_wb",    {15'h0, dp.wb_valid}, 16'h0);

    // Sum sequence: 0 AND 0, +1, +2 into r0.
    drive(0, 0, 8'h00, 16'h0, 1, 0, 1, 16'd0);
    drive(0, 1, 8'h01, 16'h1, 0, 0, 1, 16'd0);
    check("sum_wb1", {15'h0, dp.wb_valid}, 16'h1);
    drive(0, 0, 8'h00, 16'h0, 1, 0, 1, 16'd1);
    drive(0, 1, 8'h05, 16'h1, 0, 0, 1, 16'd0);
    check("sum_wb2", {15'h0, dp.wb_valid}, 16'h1);
    check("sum_r0_1", dp.reg0_out, 16'd1);
    drive(0, 0, 8'h00, 16'h0, 1, 0, 1, 16'd2);
    drive(0, 1, 8'h05, 16'h1, 0, 0, 1, 16'd0);
    check("sum_wb3", {15'h0, dp.wb_valid}, 16'h1);
    check("sum_r0_3", dp.reg0_out, 16'd3);
    check("sum_flags", {12'h0, dp.flags}, 16'h0000);

    // Signed overflow: r1=7FFF, +1 into r2.
    drive(0, 0, 8'h00, 16'h0,    0, 0, 1, 16'h7FFF);
    drive(0, 1, 8'h08, 16'h0002, 0, 0, 1, 16'h0);
    check("ovf_mov_bus", dp.bus, 16'h7FFF);
    drive(0, 0, 8'h00, 16'h0,    2, 0, 1, 16'h0001);
    drive(0, 1, 8'h05, 16'h0004, 0, 0, 1, 16'h0);
    check("ovf_bus",   dp.bus, 16'h8000);
    check("ovf_flags", {12'h0, dp.flags}, 16'h0006);
    drive(0, 1, 8'h08, 16'h0001, 0, 3, 0, 16'h0);
    check("ovf_r2_via_r0", dp.reg0_out, 16'h8000);

    // CMP 5 vs 5 with all enables set: flags only.
    drive(0, 0, 8'h00, 16'h0,    0, 0, 1, 16'd5);
    drive(0, 1, 8'h08, 16'h0008, 0, 0, 1, 16'h0);
    drive(0, 0, 8'h00, 16'h0,    4, 0, 1, 16'd5);
    drive(0, 1, 8'h07, 16'hFFFF, 0, 0, 1, 16'h0);
    check("cmp_flags", {12'h0, dp.flags}, 16'h0009);
    check("cmp_bus",   dp.bus, 16'h0005);
    check("cmp_wb",    {15'h0, dp.wb_valid}, 16'h0);
    check("cmp_r0",    dp.reg0_out, 16'h8000);

    // Illegal opcode.
    drive(0, 1, 8'hFF, 16'hFFFF, 0, 0, 1, 16'h0);
    check("ill_pulse", {15'h0, dp.illegal_op}, 16'h1);
    check("ill_flags", {12'h0, dp.flags}, 16'h0009);
    check("ill_r0",    dp.reg0_out, 16'h8000);
    check("ill_bus",   dp.bus, 16'h0005);

    // Multi-write r0 and r15, then read r15 back through control2=16.
    drive(0, 0, 8'h00, 16'h0,    0, 0, 1, 16'hBEEF);
    drive(0, 1, 8'h08, 16'h8001, 0, 0, 1, 16'h0);
    check("mw_r0", dp.reg0_out, 16'hBEEF);
    drive(0, 0, 8'h00, 16'h0,    0, 0, 1, 16'h0);
    drive(0, 1, 8'h08, 16'h0001, 0, 0, 1, 16'h0);
    check("mw_clear_r0", dp.reg0_out, 16'h0000);
    drive(0, 1, 8'h08, 16'h0001, 0, 16, 0, 16'h0);
    check("mw_r15", dp.reg0_out, 16'hBEEF);

    // control1=20 holds A (still 5); ADD 0 with enable=0.
    drive(0, 0, 8'h00, 16'h0, 20, 0, 1, 16'h0);
    drive(0, 1, 8'h05, 16'h0, 0, 0, 1, 16'h0);
    check("hold_bus", dp.bus, 16'h0005);
    check("en0_wb",   {15'h0, dp.wb_valid}, 16'h1);
    check("en0_r0",   dp.reg0_out, 16'hBEEF);

    // Execute with concurrent A load uses old A.
    drive(0, 1, 8'h04, 16'h0, 1, 0, 1, 16'h0);
    check("olda_bus", dp.bus, 16'hFFFA);
    drive(0, 1, 8'h04, 16'h0, 0, 0, 1, 16'h0);
    check("newa_bus", dp.bus, 16'h4110);

    // Reset on the same edge as an ADD.
    drive(0, 0, 8'h00, 16'h0,    1, 0, 1, 16'h0001);
    drive(1, 1, 8'h05, 16'hFFFF, 0, 0, 1, 16'h0);
    check("rmid_r0",    dp.reg0_out, 16'h0000);
    check("rmid_wb",    {15'h0, dp.wb_valid}, 16'h0);
    check("rmid_bus",   dp.bus, 16'h0000);
    check("rmid_flags", {12'h0, dp.flags}, 16'h0000);

    // Randomized traffic.
    repeat (800) begin
      logic        r_rst, r_be, r_ic;
      logic [7:0]  r_op;
      logic [15:0] r_en;
      logic [4:0]  r_c1, r_c2;
      r_rst = ($urandom_range(0, 63) == 0);
      r_be  = $urandom_range(0, 1) == 1;
      r_ic  = $urandom_range(0, 1) == 1;
      r_op  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 11));
      case ($urandom_range(0, 3))
        0:       r_en = 16'h0;
        1:       r_en = 16'h1 << $urandom_range(0, 15);
        2:       r_en = 16'h0001;
        default: r_en = 16'($urandom);
      endcase
      r_c1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 16));
      r_c2 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 16));
      rnd  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      drive(r_rst, r_be, r_op, r_en, r_c1, r_c2, r_ic, rnd);
    end

    drive(0, 0, 8'h00, 16'h0, 0, 0, 0, 16'h0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
